mmio_ram_ctrl: RTL

//   Parametrised data memory with a memory-mapped I/O window at the top of the address space,
//   for the CPU data port. Adds a reset-time init sweep with READY, a registered read port,
//   per-port output write strobes and read-back of output registers. Can export a RAM window
//   (text buffer) as a flat bus for the display driver.

---
 rtl/mmio_ram_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mmio_ram_ctrl.sv
// mmio_ram_ctrl: data memory for the CPU data port, with a memory-mapped I/O window
// at the top of the address space.
//   Map: RAM [0, RAM_DEPTH-1], input i at RAM_DEPTH+i, output j at RAM_DEPTH+N_IN+j,
//   where RAM_DEPTH = 2**ADDR_W - N_IN - N_OUT.
//   After RESET an init sweep writes INIT_VAL into every RAM word. READY rises when
//   the sweep is done, and accesses are ignored until then.
// Ports:
//   CLK, RESET   clock; synchronous active-high reset
//   ADDR, DATA   word address / write data
//   MW           write enable
//   Q            registered read data (latency 1, read-first)
//   READY        init sweep complete
//   IN_BUS       N_IN read-only input ports
//   OUT_BUS      N_OUT output registers (read/write)
//   OUT_STB      one-cycle strobe per output register, aligned with its new value
//   DISP         flat view of RAM[DISP_BASE +: DISP_LEN], word 0 in the MSBs
// Optional feature: define MMIO_RAM_DISP_TAP_EN to drive DISP from the RAM.
//   Without it DISP is 0 and the RAM keeps a single read port.
module mmio_ram_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int N_IN      = 2,
  parameter int N_OUT     = 6,
  parameter logic [DATA_W-1:0] INIT_VAL = 'h20,
  parameter int DISP_BASE = 64,
  parameter int DISP_LEN  = 64
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [ADDR_W-1:0]          ADDR,
  input  logic [DATA_W-1:0]          DATA,
  input  logic                       MW,
  output logic [DATA_W-1:0]          Q,
  output logic                       READY,
  input  logic [N_IN*DATA_W-1:0]     IN_BUS,
  output logic [N_OUT*DATA_W-1:0]    OUT_BUS,
  output logic [N_OUT-1:0]           OUT_STB,
  output logic [DISP_LEN*DATA_W-1:0] DISP
);

  localparam int RAM_DEPTH = (2**ADDR_W) - N_IN - N_OUT;
  localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] RAM_LAST = ADDR_W'(RAM_DEPTH - 1);

  if (RAM_DEPTH < 1 || DISP_BASE + DISP_LEN > RAM_DEPTH) begin : g_bad_cfg
    $error("mmio_ram_ctrl: RAM_DEPTH < 1 or display window outside RAM");
  end

  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]             cnt;
  logic [DATA_W-1:0]             ram [RAM_DEPTH];
  logic [DATA_W-1:0]             ram_q;
  logic [N_OUT-1:0][DATA_W-1:0]  out_r;
  logic [N_OUT-1:0]              out_hit;
  logic [DATA_W-1:0]             io_word, io_q;
  logic                          sel_ram;
  logic                          is_ram;
  logic                          run;
  logic                          ram_we;
  logic [ADDR_W-1:0]             ram_wa;
  logic [DATA_W-1:0]             ram_wd;

  assign is_ram = ADDR < RAM_TOP;

  // Address decode of the I/O window; output reads return the register's current value.
  always_comb begin
    out_hit = '0;
    io_word = '0;
    for (int i = 0; i < N_IN; i++)
      if (ADDR == ADDR_W'(RAM_DEPTH + i)) io_word = IN_BUS[i*DATA_W +: DATA_W];
    for (int j = 0; j < N_OUT; j++)
      if (ADDR == ADDR_W'(RAM_DEPTH + N_IN + j)) begin
        out_hit[j] = 1'b1;
        io_word    = out_r[j];
      end
  end

  // FSM state register and sweep counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end

  // Next state and the single RAM write port: the sweep owns it in INIT, the CPU in RUN.
  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    ram_we    = 1'b0;
    ram_wa    = cnt;
    ram_wd    = INIT_VAL;
    case (state)
      INIT: begin
        ram_we = 1'b1;
        if (cnt == RAM_LAST) state_nxt = RUN;
      end
      RUN: begin
        run    = 1'b1;
        ram_we = MW && is_ram;
        ram_wa = ADDR;
        ram_wd = DATA;
      end
      default: state_nxt = INIT;
    endcase
    // RAM keeps its contents while RESET is held
    if (RESET) begin
      ram_we = 1'b0;
      run    = 1'b0;
    end
  end

  // RAM: no reset, read-first registered read so it maps onto block RAM
  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    ram_q <= ram[is_ram ? ADDR : '0];
  end

  // I/O registers, read-path select and strobes
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel_ram <= 1'b0;
      io_q    <= '0;
      out_r   <= '0;
      OUT_STB <= '0;
    end else begin
      // In INIT both are cleared, which holds Q at 0
      sel_ram <= run && is_ram;
      io_q    <= run ? io_word : '0;
      OUT_STB <= (run && MW) ? out_hit : '0;
      for (int j = 0; j < N_OUT; j++)
        if (run && MW && out_hit[j]) out_r[j] <= DATA;
    end
  end

  assign Q       = sel_ram ? ram_q : io_q;
  assign READY   = (state == RUN);
  assign OUT_BUS = out_r;

`ifdef MMIO_RAM_DISP_TAP_EN
  always_comb begin
    DISP = '0;
    for (int k = 0; k < DISP_LEN; k++)
      DISP[(DISP_LEN-k)*DATA_W-1 -: DATA_W] = ram[DISP_BASE + k];
  end
`else
  assign DISP = '0;
`endif

endmodule
